// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small synchronous FIFO. Words are serialised
// LSB first with an optional parity bit and one or two stop bits. Frames
// follow each other with no idle gap while the FIFO holds data.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE     = 19_200,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY_MODE   = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty
);

  localparam int unsigned BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(BAUD_CLOCKS);
  localparam int unsigned NW = $clog2(DATA_BITS);

  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_CLOCKS - 1);
  localparam logic [NW-1:0] DATA_LAST  = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] STOP_LAST  = NW'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;
  logic                 push;
  logic                 pop;

  // Serialiser state
  state_t               state, state_nx;
  logic [BW-1:0]        baud_cnt, baud_nx;
  logic [NW-1:0]        bit_cnt, bit_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 par_bit, par_nx;
  logic                 tx_nx;
  logic                 busy_nx;
  logic                 baud_end;

  assign fifo_count = count;
  assign fifo_empty = (count == '0);
  assign din_ready  = (count != FULL_COUNT);
  assign push       = din_valid && din_ready;
  assign head       = mem[rd_ptr];
  assign head_par   = (PARITY_MODE == 2) ? ~^head : ^head;
  assign baud_end   = (baud_cnt == BAUD_LAST);

  // FIFO array write; contents need no reset because count gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Serialiser state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      shreg    <= shreg_nx;
      par_bit  <= par_nx;
      tx_out   <= tx_nx;
      busy     <= busy_nx;
    end
  end

  // Next-state and registered-output decode; tx_out is computed one cycle
  // ahead so the line changes exactly on each bit boundary edge
  always_comb begin
    state_nx = state;
    baud_nx  = baud_end ? '0 : baud_cnt + 1'b1;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    par_nx   = par_bit;
    tx_nx    = tx_out;
    busy_nx  = busy;
    pop      = 1'b0;

    unique case (state)
      S_IDLE: begin
        baud_nx = '0;
        tx_nx   = 1'b1;
        busy_nx = 1'b0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shreg_nx = head;
          par_nx   = head_par;
          tx_nx    = 1'b0;
          busy_nx  = 1'b1;
          state_nx = S_START;
        end
      end

      S_START: begin
        if (baud_end) begin
          bit_nx   = '0;
          tx_nx    = shreg[0];
          state_nx = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_end) begin
          if (bit_cnt == DATA_LAST) begin
            bit_nx = '0;
            if (PARITY_MODE != 0) begin
              tx_nx    = par_bit;
              state_nx = S_PARITY;
            end else begin
              tx_nx    = 1'b1;
              state_nx = S_STOP;
            end
          end else begin
            bit_nx   = bit_cnt + 1'b1;
            shreg_nx = shreg >> 1;
            tx_nx    = shreg[1];
          end
        end
      end

      S_PARITY: begin
        if (baud_end) begin
          bit_nx   = '0;
          tx_nx    = 1'b1;
          state_nx = S_STOP;
        end
      end

      S_STOP: begin
        if (baud_end) begin
          if (bit_cnt == STOP_LAST) begin
            bit_nx = '0;
            if (!fifo_empty) begin
              // Back-to-back frame: reload straight into START, no idle bit
              pop      = 1'b1;
              shreg_nx = head;
              par_nx   = head_par;
              tx_nx    = 1'b0;
              state_nx = S_START;
            end else begin
              busy_nx  = 1'b0;
              state_nx = S_IDLE;
            end
          end else begin
            bit_nx = bit_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nx = S_IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances (8N1, 8E1, 8O2) at
// 10 clocks per bit, with a bit-sampling receiver model on the line.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] din0, din1, din2;
  logic       v0, v1, v2;
  logic       rdy0, rdy1, rdy2;
  logic       tx0, tx1, tx2;
  logic       bsy0, bsy1, bsy2;
  logic [3:0] cnt0, cnt1, cnt2;
  logic       emp0, emp1, emp2;

  int n_checks;
  int n_errors;

  uart_tx_fifo #(
    .CLK_FREQUENCY(100_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(8),
    .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(8)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din0), .din_valid(v0), .din_ready(rdy0),
    .tx_out(tx0), .busy(bsy0), .fifo_count(cnt0), .fifo_empty(emp0)
  );

  uart_tx_fifo #(
    .CLK_FREQUENCY(100_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(8),
    .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(8)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(v1), .din_ready(rdy1),
    .tx_out(tx1), .busy(bsy1), .fifo_count(cnt1), .fifo_empty(emp1)
  );

  uart_tx_fifo #(
    .CLK_FREQUENCY(100_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(8),
    .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(8)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .din_valid(v2), .din_ready(rdy2),
    .tx_out(tx2), .busy(bsy2), .fifo_count(cnt2), .fifo_empty(emp2)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic line(input int s);
    case (s)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic bsy(input int s);
    case (s)
      0:       return bsy0;
      1:       return bsy1;
      default: return bsy2;
    endcase
  endfunction

  function automatic logic [3:0] cnt(input int s);
    case (s)
      0:       return cnt0;
      1:       return cnt1;
      default: return cnt2;
    endcase
  endfunction

  task automatic drive(input int s, input logic [7:0] w, input logic v);
    case (s)
      0:       begin din0 = w; v0 = v; end
      1:       begin din1 = w; v1 = v; end
      default: begin din2 = w; v2 = v; end
    endcase
  endtask

  // Wait (bounded) for the line to fall; returns on the first negedge it reads 0
  task automatic wait_fall(input int s, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (line(s) !== 1'b0 && k < budget);
    check("fall_timeout", line(s), 1'b0);
  endtask

  // Entered on the first negedge after the start-bit edge (p=0). Samples each
  // bit mid-period and leaves on the negedge one frame length later.
  task automatic check_frame(input int s, input logic [7:0] w, input int pm,
                             input int sb, input bit last);
    logic [7:0] rx;
    logic       exp_par;
    repeat (5) @(negedge clk);
    check("start_bit", line(s), 1'b0);
    check("busy_mid", bsy(s), 1'b1);
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      rx[i] = line(s);
    end
    check("rx_word", rx, w);
    if (pm != 0) begin
      exp_par = (pm == 1) ? ^w : ~^w;
      repeat (10) @(negedge clk);
      check("parity_bit", line(s), exp_par);
    end
    for (int j = 0; j < sb; j++) begin
      repeat (10) @(negedge clk);
      check("stop_bit", line(s), 1'b1);
    end
    repeat (4) @(negedge clk);
    check("busy_end", bsy(s), 1'b1);
    check("stop_end", line(s), 1'b1);
    @(negedge clk);
    if (last) begin
      check("busy_fall", bsy(s), 1'b0);
      check("idle_line", line(s), 1'b1);
    end else begin
      check("no_gap", line(s), 1'b0);
      check("busy_cont", bsy(s), 1'b1);
    end
  endtask

  // One word into an idle instance: latency check then full frame check
  task automatic send_single(input int s, input logic [7:0] w, input int pm, input int sb);
    drive(s, w, 1'b1);
    @(negedge clk);
    drive(s, 8'h00, 1'b0);
    check("lat_edge1_tx", line(s), 1'b1);
    check("lat_edge1_cnt", cnt(s), 4'd1);
    @(negedge clk);
    check("lat_edge2_tx", line(s), 1'b0);
    check("lat_edge2_busy", bsy(s), 1'b1);
    check("lat_edge2_cnt", cnt(s), 4'd0);
    check_frame(s, w, pm, sb, 1'b1);
  endtask

  initial begin
    bit saw_low;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    din0 = '0; din1 = '0; din2 = '0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;

    // Reset held 80 ns, released on a negedge
    #80;
    rst_n = 1'b1;
    check("rst_tx", tx0, 1'b1);
    check("rst_busy", bsy0, 1'b0);
    check("rst_ready", rdy0, 1'b1);
    check("rst_count", cnt0, 4'd0);
    check("rst_empty", emp0, 1'b1);
    check("rst_tx2", tx2, 1'b1);
    repeat (2) @(negedge clk);

    // 8N1 single word
    send_single(0, 8'hA5, 0, 1);
    repeat (3) @(negedge clk);

    // Even parity 0x07 -> parity 1, 110 clk; odd parity + 2 stop -> parity 0, 120 clk
    send_single(1, 8'h07, 1, 1);
    repeat (3) @(negedge clk);
    send_single(2, 8'h07, 2, 2);
    repeat (3) @(negedge clk);

    // Nine back-to-back pushes: first pops at once, rest fill the FIFO;
    // 0xFF offered while full must be dropped
    fork
      begin
        wait_fall(0, 20);
        for (int i = 1; i <= 9; i++) begin
          check_frame(0, 8'(i), 0, 1, i == 9);
        end
      end
      begin
        for (int i = 1; i <= 9; i++) begin
          drive(0, 8'(i), 1'b1);
          @(negedge clk);
        end
        drive(0, 8'hFF, 1'b1);
        check("full_count", cnt0, 4'd8);
        check("full_ready", rdy0, 1'b0);
        check("full_empty", emp0, 1'b0);
        repeat (30) @(negedge clk);
        check("full_hold_count", cnt0, 4'd8);
        check("full_hold_ready", rdy0, 1'b0);
        drive(0, 8'h00, 1'b0);
      end
    join
    repeat (50) @(negedge clk);
    check("drain_count", cnt0, 4'd0);
    check("drain_tx", tx0, 1'b1);
    check("drain_busy", bsy0, 1'b0);

    // Reset during data bit 3 with four words queued
    for (int i = 0; i < 5; i++) begin
      drive(0, 8'h3C + 8'(i), 1'b1);
      @(negedge clk);
    end
    drive(0, 8'h00, 1'b0);
    repeat (42) @(negedge clk);
    check("pre_rst_count", cnt0, 4'd4);
    check("pre_rst_busy", bsy0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx0, 1'b1);
    check("mid_rst_busy", bsy0, 1'b0);
    check("mid_rst_count", cnt0, 4'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || bsy0 !== 1'b0) saw_low = 1'b1;
    end
    check("post_rst_quiet", saw_low, 1'b0);
    check("post_rst_count", cnt0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
